wb_cmd_master: RTL
==================

// Module: wb_cmd_master
// PURPOSE
//  Wishbone classic initiator driving the Vthernet CSR/RX-memory slave (MAC/IP/port/offload CSRs,
//  RX buffer at 0x4000_0000). Converts a valid/ready command stream (single reads/writes) into one
//  bus cycle each and returns data/status on a valid/ready response stream. Used by the
//  boot-time config loader and by benches; one outstanding transaction, with an ack timeout.
// PARAMETERS
//  TIMEOUT_CYCLES  255  cycles in BUS without ack before abort; 0 disables timeout
//  STB_ONE_SHOT    1    1: stb high for first BUS cycle only, cyc held to ack; 0: stb held with cyc
// PORTS
//  wb_clk_i     in   1   bus clock, sole clock
//  wb_rst_ni    in   1   asynchronous, active-low reset
//  cmd_valid_i  in   1   command offered
//  cmd_ready_o  out  1   command accepted when valid&ready
//  cmd_we_i     in   1   1 = write, 0 = read
//  cmd_adr_i    in   32  byte address
//  cmd_dat_i    in   32  write data
//  cmd_sel_i    in   4   byte selects
//  rsp_valid_o  out  1   response available
//  rsp_ready_i  in   1   response consumed when valid&ready
//  rsp_dat_o    out  32  read data (0 for writes and on error)
//  rsp_err_o    out  1   1 = timeout abort
//  wbm_cyc_o    out  1   Wishbone cyc
//  wbm_stb_o    out  1   Wishbone stb
//  wbm_we_o     out  1   Wishbone we
//  wbm_sel_o    out  4   Wishbone sel
//  wbm_adr_o    out  32  Wishbone address
//  wbm_dat_o    out  32  Wishbone write data
//  wbm_ack_i    in   1   Wishbone ack
//  wbm_dat_i    in   32  Wishbone read data
// BEHAVIOUR
//  - All outputs registered. Reset (async, wb_rst_ni=0): state IDLE, cyc/stb/we=0, sel=0, adr=0,
//    dat=0, rsp_valid=0, rsp_dat=0, rsp_err=0, timeout counter=0; cmd_ready_o=0 while in reset.
//  - States: IDLE -> BUS -> RESP -> IDLE.
//  - IDLE: cmd_ready_o=1. On cmd_valid_i: latch we/adr/dat/sel onto wbm_*, cyc=1, stb=1, cnt=0,
//    go BUS. cmd_ready_o=0 in BUS and RESP (single outstanding).
//  - BUS: STB_ONE_SHOT=1 -> stb drops after first BUS cycle; =0 -> stb follows cyc.
//    ack sampled high (incl. same edge stb drops): cyc=stb=0, rsp_dat=we?0:wbm_dat_i, rsp_err=0,
//    rsp_valid=1, go RESP. ack ignored in IDLE/RESP.
//  - Timeout: cnt increments each BUS cycle without ack; cnt==TIMEOUT_CYCLES-1 and no ack ->
//    cyc=stb=0, rsp_err=1, rsp_dat=0, go RESP. Ack on that same edge wins (normal completion).
//  - RESP: hold rsp_valid/dat/err stable until rsp_ready_i; then rsp_valid=0, go IDLE. Next command
//    accepted no earlier than the cycle after IDLE is re-entered (min 4 cycles cmd-to-cmd).
//  - Latency: cmd accept edge -> cyc/stb high next cycle; ack edge -> rsp_valid high next cycle.
//  - wbm_adr/dat/sel/we stable for the whole cyc; cleared to 0 on return to IDLE.
//  - Reset mid-BUS: cyc/stb drop asynchronously; transaction and response discarded.
//  - cmd_* inputs changing while not ready: ignored; no width conversion, 32-bit transfers only.
// TESTING
//  - Write 0x3000_0008 dat 0xC0A8_0001 sel 0xF, ack 1 cycle later -> one cyc window, we=1, stb 1 cycle,
//    rsp_valid with err=0 dat=0; slave IP CSR reads back 0xC0A8_0001.
//  - Read 0x3000_0004 (MAC high) after reset -> rsp_dat=0x0000_0100, err=0, exactly one bus cycle.
//  - No ack, TIMEOUT_CYCLES=8 -> cyc low after 8 BUS cycles, rsp_err=1, rsp_dat=0; later ack ignored.
//  - rsp_ready_i held 0 for 10 cycles -> rsp held stable, cmd_ready_o=0, new cmd_valid not accepted.
//  - Back-to-back read 0x4000_0000 then write 0x3000_0024, rsp_ready_i=1 -> two distinct cyc windows,
//    in order, each stb one cycle (STB_ONE_SHOT=1), no merged or duplicated transfers.
//  - wb_rst_ni pulsed low mid-BUS -> cyc/stb/rsp_valid 0 immediately; accepts next command normally.

Source files
------------

// File: rtl/wb_cmd_master.sv
// ---------------------------------------------------------------------------
// wb_cmd_master
//   Wishbone classic initiator for the Vthernet CSR / RX-memory slave.
//   Accepts single read/write commands on a valid/ready stream, runs exactly
//   one bus cycle per command, and returns read data and status on a
//   valid/ready response stream. Only one transaction is outstanding at a
//   time. A bus cycle without ack is aborted after TIMEOUT_CYCLES cycles.
//
// Parameters
//   TIMEOUT_CYCLES : BUS-state cycles without ack before abort (0 = never)
//   STB_ONE_SHOT   : 1 = stb only in the first BUS cycle, 0 = stb follows cyc
//
// Ports
//   wb_clk_i, wb_rst_ni          clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o    command handshake
//   cmd_we_i, cmd_adr_i,
//   cmd_dat_i, cmd_sel_i         command payload (write flag, byte address,
//                                write data, byte selects)
//   rsp_valid_o / rsp_ready_i    response handshake
//   rsp_dat_o, rsp_err_o         read data (0 for writes/errors), timeout flag
//   wbm_*                        Wishbone classic initiator signals
// ---------------------------------------------------------------------------
module wb_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          STB_ONE_SHOT   = 1'b1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,

    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,

    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,

    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               cmd_ready_d;
    logic               cyc_d, stb_d, we_d;
    logic [3:0]         sel_d;
    logic [31:0]        adr_d, dat_d;
    logic               rsp_valid_d, rsp_err_d;
    logic [31:0]        rsp_dat_d;

    // Next-state / next-output logic.
    // NOTE: every signal gets a default before the case; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_ready_d = 1'b0;
        cyc_d       = wbm_cyc_o;
        stb_d       = wbm_stb_o;
        we_d        = wbm_we_o;
        sel_d       = wbm_sel_o;
        adr_d       = wbm_adr_o;
        dat_d       = wbm_dat_o;
        rsp_valid_d = rsp_valid_o;
        rsp_dat_d   = rsp_dat_o;
        rsp_err_d   = rsp_err_o;

        unique case (state_q)
            S_IDLE: begin
                // Ready rises one cycle after IDLE is (re-)entered, so a
                // command is never taken on the same edge that ends RESP.
                cmd_ready_d = 1'b1;
                if (cmd_ready_o && cmd_valid_i) begin
                    cmd_ready_d = 1'b0;
                    we_d        = cmd_we_i;
                    adr_d       = cmd_adr_i;
                    dat_d       = cmd_dat_i;
                    sel_d       = cmd_sel_i;
                    cyc_d       = 1'b1;
                    stb_d       = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_BUS;
                end
            end

            S_BUS: begin
                if (STB_ONE_SHOT) begin
                    stb_d = 1'b0;
                end
                if (wbm_ack_i) begin
                    // Ack beats a timeout expiring on the same edge.
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_dat_d   = wbm_we_o ? 32'h0 : wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (cnt_q == CNT_LAST) begin
                        cyc_d       = 1'b0;
                        stb_d       = 1'b0;
                        rsp_dat_d   = 32'h0;
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = S_RESP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            S_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    we_d        = 1'b0;
                    sel_d       = 4'h0;
                    adr_d       = 32'h0;
                    dat_d       = 32'h0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs. Asynchronous reset drops cyc/stb at once
    // and discards any transaction in flight.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cmd_ready_o <= 1'b0;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_sel_o   <= 4'h0;
            wbm_adr_o   <= 32'h0;
            wbm_dat_o   <= 32'h0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= 32'h0;
            rsp_err_o   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready_o <= cmd_ready_d;
            wbm_cyc_o   <= cyc_d;
            wbm_stb_o   <= stb_d;
            wbm_we_o    <= we_d;
            wbm_sel_o   <= sel_d;
            wbm_adr_o   <= adr_d;
            wbm_dat_o   <= dat_d;
            rsp_valid_o <= rsp_valid_d;
            rsp_dat_o   <= rsp_dat_d;
            rsp_err_o   <= rsp_err_d;
        end
    end

endmodule
